// File: rtl/mem_copy_pkg.sv
// Shared types and default sizes for the memory copy engine.
package mem_copy_pkg;
  localparam int MC_AW = 8;
  localparam int MC_DW = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;
  typedef enum logic {ASC, DESC} dir_e;
endpackage

// File: rtl/mem_copy_addr_gen.sv
// Loadable up/down address counter; wraps naturally modulo 2**AW.
module mem_copy_addr_gen
  import mem_copy_pkg::*;
#(
  parameter int AW = MC_AW
)
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  dir_e          load_dir,
  input  logic          step,
  output logic [AW-1:0] addr
);
  logic [AW-1:0] addr_reg;
  logic [AW-1:0] addr_next;
  dir_e          dir_reg;

  always_comb begin
    addr_next = addr_reg;
    if (load)
      addr_next = load_addr;
    else if (step)
      addr_next = (dir_reg == DESC) ? addr_reg - AW'(1) : addr_reg + AW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_reg <= '0;
      dir_reg  <= ASC;
    end else begin
      addr_reg <= addr_next;
      if (load)
        dir_reg <= load_dir;
    end
  end

  assign addr = addr_reg;
endmodule

// File: rtl/mem_copy_engine.sv
// Overlap-safe block copy initiator for a sync memory, one word per cycle.
// Optional MEM_COPY_CHKSUM_EN adds a CHKSUM output summing every written word.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AW = MC_AW,
  parameter int DW = MC_DW
)
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] SRC,
  input  logic [AW-1:0] DST,
  input  logic [AW:0]   LEN,
  input  logic          ABORT,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW:0]   COUNT,
  output logic [AW-1:0] R_ADDR,
  input  logic [DW-1:0] R_DATA,
  output logic [AW-1:0] W_ADDR,
  output logic [DW-1:0] W_DATA,
`ifdef MEM_COPY_CHKSUM_EN
  output logic [DW-1:0] CHKSUM,
`endif
  output logic          W_WE
);
  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

  state_e        state_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          we_reg;
  logic [AW:0]   count_reg;
  logic [AW:0]   rd_left_reg;

  logic          start_ok;
  logic [AW:0]   len_c;
  logic [AW-1:0] diff;
  dir_e          dir;
  logic [AW-1:0] src_first;
  logic [AW-1:0] dst_first;
  logic          gen_load;
  logic          last_read;
  logic [AW-1:0] gen_first [2];
  logic          gen_step  [2];
  logic [AW-1:0] gen_addr  [2];

  // A new request is accepted whenever the engine is not busy, FIN included.
  assign start_ok  = START && ((state_reg == IDLE) || (state_reg == FIN));
  assign len_c     = (LEN > MAX_LEN) ? MAX_LEN : LEN;
  assign diff      = DST - SRC;
  assign dir       = ((DST > SRC) && ({1'b0, diff} < len_c)) ? DESC : ASC;
  assign src_first = (dir == DESC) ? SRC + len_c[AW-1:0] - AW'(1) : SRC;
  assign dst_first = (dir == DESC) ? DST + len_c[AW-1:0] - AW'(1) : DST;
  assign gen_load  = start_ok && (len_c != '0);
  assign last_read = (rd_left_reg == LEN_ONE);

  assign gen_first[0] = src_first;
  assign gen_first[1] = dst_first;
  // Dst only advances between two consecutive write cycles so W_ADDR lines up with R_DATA.
  assign gen_step[0]  = (state_reg == RUN) && !ABORT && !last_read;
  assign gen_step[1]  = (state_reg == RUN) && !ABORT && we_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_addr
      mem_copy_addr_gen #(.AW(AW)) u_gen (
        .CLK       (CLK),
        .RST       (RST),
        .load      (gen_load),
        .load_addr (gen_first[gi]),
        .load_dir  (dir),
        .step      (gen_step[gi]),
        .addr      (gen_addr[gi])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      we_reg      <= 1'b0;
      count_reg   <= '0;
      rd_left_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (we_reg)
        count_reg <= count_reg + (AW+1)'(1);
      case (state_reg)
        IDLE, FIN: begin
          state_reg <= IDLE;
          if (START) begin
            count_reg <= '0;
            if (len_c == '0) begin
              state_reg <= FIN;
              done_reg  <= 1'b1;
            end else begin
              state_reg   <= RUN;
              busy_reg    <= 1'b1;
              rd_left_reg <= len_c;
            end
          end
        end
        RUN: begin
          rd_left_reg <= rd_left_reg - (AW+1)'(1);
          if (ABORT) begin
            state_reg <= FIN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            we_reg    <= 1'b0;
          end else begin
            we_reg <= 1'b1;
            if (last_read)
              state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          state_reg <= FIN;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          we_reg    <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef MEM_COPY_CHKSUM_EN
  logic [DW-1:0] chk_reg;

  always_ff @(posedge CLK) begin
    if (RST)
      chk_reg <= '0;
    else if (start_ok)
      chk_reg <= '0;
    else if (we_reg)
      chk_reg <= chk_reg + W_DATA;
  end

  assign CHKSUM = chk_reg;
`endif

  assign BUSY   = busy_reg;
  assign DONE   = done_reg;
  assign COUNT  = count_reg;
  assign R_ADDR = gen_addr[0];
  assign W_ADDR = gen_addr[1];
  assign W_WE   = we_reg;
  assign W_DATA = we_reg ? R_DATA : '0;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench: engine wrapped around a 256x16 sync memory model with a bulk-fill port.
module tb_mem_copy_engine;
  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        ABORT;
  logic [7:0]  SRC;
  logic [7:0]  DST;
  logic [8:0]  LEN;
  logic        BUSY;
  logic        DONE;
  logic [8:0]  COUNT;
  logic [7:0]  R_ADDR;
  logic [15:0] R_DATA;
  logic [7:0]  W_ADDR;
  logic [15:0] W_DATA;
  logic        W_WE;
`ifdef MEM_COPY_CHKSUM_EN
  logic [15:0] CHKSUM;
`endif

  logic [15:0] mem [256];
  logic        fill_req;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;

  // Memory: registered read address, write port for the engine, bulk fill as the second port.
  always @(posedge CLK) begin
    R_DATA <= mem[R_ADDR];
    if (fill_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
    end else if (W_WE) begin
      mem[W_ADDR] <= W_DATA;
    end
  end

  mem_copy_engine #(.AW(8), .DW(16)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .SRC    (SRC),
    .DST    (DST),
    .LEN    (LEN),
    .ABORT  (ABORT),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .COUNT  (COUNT),
    .R_ADDR (R_ADDR),
    .R_DATA (R_DATA),
    .W_ADDR (W_ADDR),
    .W_DATA (W_DATA),
`ifdef MEM_COPY_CHKSUM_EN
    .CHKSUM (CHKSUM),
`endif
    .W_WE   (W_WE)
  );

  task automatic step_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_mem();
    step_cycle();
    fill_req = 1'b1;
    step_cycle();
    fill_req = 1'b0;
  endtask

  // Issues one request and follows it until DONE; cycle 1 is the cycle after START is sampled.
  task automatic run_copy(input logic [7:0] src, input logic [7:0] dst, input logic [8:0] len,
                          output int done_cyc, output int writes, output int busy_cyc,
                          output logic [8:0] cnt);
    int cyc;
    step_cycle();
    SRC = src; DST = dst; LEN = len; START = 1'b1;
    step_cycle();
    START = 1'b0;
    cyc = 1; done_cyc = 0; writes = 0; busy_cyc = 0; cnt = '0;
    while (done_cyc == 0 && cyc < 600) begin
      if (W_WE) writes++;
      if (BUSY) busy_cyc++;
      if (DONE) begin
        done_cyc = cyc;
        cnt = COUNT;
      end else begin
        step_cycle();
        cyc++;
      end
    end
    $display("copy src=%02h dst=%02h len=%0d done_cycle=%0d writes=%0d busy=%0d count=%0d",
             src, dst, len, done_cyc, writes, busy_cyc, cnt);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step_cycle();
    step_cycle();
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", DONE); end
    checks++; if (COUNT !== 9'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", COUNT); end
    checks++; if (R_ADDR !== 8'd0 || W_ADDR !== 8'd0) begin errors++; $display("FAIL reset_addr got r=%0h w=%0h expected 0/0", R_ADDR, W_ADDR); end
    checks++; if (W_WE !== 1'b0 || W_DATA !== 16'd0) begin errors++; $display("FAIL reset_write got we=%b data=%0h expected 0/0", W_WE, W_DATA); end
    RST = 1'b0;
  endtask

  task automatic test_basic();
    int d, w, b; logic [8:0] c;
    fill_mem();
    run_copy(8'h10, 8'h80, 9'd4, d, w, b, c);
    checks++; if (d !== 6) begin errors++; $display("FAIL basic_done_cycle got %0d expected 6", d); end
    checks++; if (w !== 4) begin errors++; $display("FAIL basic_writes got %0d expected 4", w); end
    checks++; if (b !== 5) begin errors++; $display("FAIL basic_busy_cycles got %0d expected 5", b); end
    checks++; if (c !== 9'd4) begin errors++; $display("FAIL basic_count got %0d expected 4", c); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h80 + i] !== 16'(8'h10 + i)) begin
        errors++; $display("FAIL basic_mem[%0h] got %0h expected %0h", 8'h80 + i, mem[8'h80 + i], 8'h10 + i);
      end
    end
    checks++; if (mem[8'h84] !== 16'h0084) begin errors++; $display("FAIL basic_mem_past_end got %0h expected 84", mem[8'h84]); end
    step_cycle();
    checks++; if (DONE !== 1'b0 || COUNT !== 9'd4) begin errors++; $display("FAIL basic_hold got done=%b count=%0d expected 0/4", DONE, COUNT); end
  endtask

  task automatic test_overlap();
    int d, w, b; logic [8:0] c;
    fill_mem();
    run_copy(8'h20, 8'h22, 9'd8, d, w, b, c);
    checks++; if (d !== 10 || c !== 9'd8) begin errors++; $display("FAIL overlap_done got cycle=%0d count=%0d expected 10/8", d, c); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[8'h22 + i] !== 16'(8'h20 + i)) begin
        errors++; $display("FAIL overlap_mem[%0h] got %0h expected %0h", 8'h22 + i, mem[8'h22 + i], 8'h20 + i);
      end
    end
    checks++; if (mem[8'h20] !== 16'h0020 || mem[8'h21] !== 16'h0021) begin errors++; $display("FAIL overlap_src_head got %0h %0h expected 20 21", mem[8'h20], mem[8'h21]); end
  endtask

  task automatic test_wrap();
    int d, w, b; logic [8:0] c;
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h00FE; exp_w[1] = 16'h00FF; exp_w[2] = 16'h0000; exp_w[3] = 16'h0001;
    fill_mem();
    run_copy(8'hFE, 8'h40, 9'd4, d, w, b, c);
    checks++; if (w !== 4) begin errors++; $display("FAIL wrap_writes got %0d expected 4", w); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h40 + i] !== exp_w[i]) begin
        errors++; $display("FAIL wrap_mem[%0h] got %0h expected %0h", 8'h40 + i, mem[8'h40 + i], exp_w[i]);
      end
    end
  endtask

  task automatic test_len_edges();
    int d, w, b; logic [8:0] c;
    run_copy(8'h10, 8'h80, 9'd0, d, w, b, c);
    checks++; if (d !== 1) begin errors++; $display("FAIL len0_done_cycle got %0d expected 1", d); end
    checks++; if (w !== 0 || b !== 0) begin errors++; $display("FAIL len0_activity got writes=%0d busy=%0d expected 0/0", w, b); end
    checks++; if (c !== 9'd0) begin errors++; $display("FAIL len0_count got %0d expected 0", c); end
    // Full-memory ASC shift down by one: the last word reads address 0 after word 0 rewrote it.
    fill_mem();
    run_copy(8'h01, 8'h00, 9'h1FF, d, w, b, c);
    checks++; if (d !== 258) begin errors++; $display("FAIL clamp_done_cycle got %0d expected 258", d); end
    checks++; if (w !== 256) begin errors++; $display("FAIL clamp_writes got %0d expected 256", w); end
    checks++; if (c !== 9'h100) begin errors++; $display("FAIL clamp_count got %0d expected 256", c); end
    checks++; if (mem[8'h00] !== 16'h0001 || mem[8'h7F] !== 16'h0080 || mem[8'hFE] !== 16'h00FF)
      begin errors++; $display("FAIL clamp_mem got %0h %0h %0h expected 1 80 ff", mem[8'h00], mem[8'h7F], mem[8'hFE]); end
    checks++; if (mem[8'hFF] !== 16'h0001) begin errors++; $display("FAIL clamp_mem_last got %0h expected 1", mem[8'hFF]); end
  endtask

  task automatic test_abort();
    int writes;
    logic stray;
    fill_mem();
    step_cycle();
    SRC = 8'h10; DST = 8'h80; LEN = 9'd10; START = 1'b1;
    step_cycle();                       // cycle 1
    START = 1'b0;
    writes = 0;
    step_cycle();                       // cycle 2
    if (W_WE) writes++;
    step_cycle();                       // cycle 3
    if (W_WE) writes++;
    ABORT = 1'b1;
    START = 1'b1; SRC = 8'h00; DST = 8'hC0; LEN = 9'd5;
    step_cycle();                       // cycle 4
    ABORT = 1'b0; START = 1'b0;
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL abort_done got done=%b busy=%b expected 1/0", DONE, BUSY); end
    checks++; if (COUNT !== 9'd2 || writes !== 2) begin errors++; $display("FAIL abort_count got count=%0d writes=%0d expected 2/2", COUNT, writes); end
    $display("abort at cycle 3: count=%0d writes=%0d", COUNT, writes);
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (W_WE || BUSY) stray = 1'b1;
      step_cycle();
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL abort_quiet got activity=%b expected 0", stray); end
    checks++; if (mem[8'h80] !== 16'h0010 || mem[8'h81] !== 16'h0011 || mem[8'h82] !== 16'h0082)
      begin errors++; $display("FAIL abort_mem got %0h %0h %0h expected 10 11 82", mem[8'h80], mem[8'h81], mem[8'h82]); end
    checks++; if (mem[8'hC0] !== 16'h00C0) begin errors++; $display("FAIL busy_start_ignored got %0h expected c0", mem[8'hC0]); end
  endtask

  task automatic test_abort_vs_start();
    int cyc;
    step_cycle();
    SRC = 8'h10; DST = 8'h90; LEN = 9'd3; START = 1'b1; ABORT = 1'b1;
    step_cycle();
    START = 1'b0; ABORT = 1'b0;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL start_wins_busy got %b expected 1", BUSY); end
    cyc = 1;
    while (DONE !== 1'b1 && cyc < 50) begin
      step_cycle();
      cyc++;
    end
    checks++; if (cyc !== 5 || COUNT !== 9'd3) begin errors++; $display("FAIL start_wins_done got cycle=%0d count=%0d expected 5/3", cyc, COUNT); end
    $display("start+abort idle: done_cycle=%0d count=%0d", cyc, COUNT);
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    fill_mem();
    step_cycle();
    SRC = 8'h10; DST = 8'h80; LEN = 9'd10; START = 1'b1;
    step_cycle();                       // cycle 1
    START = 1'b0;
    step_cycle();                       // cycle 2
    step_cycle();                       // cycle 3
    step_cycle();                       // cycle 4
    checks++; if (COUNT !== 9'd2 || BUSY !== 1'b1) begin errors++; $display("FAIL mid_pre_reset got count=%0d busy=%b expected 2/1", COUNT, BUSY); end
    RST = 1'b1;
    step_cycle();
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || COUNT !== 9'd0)
      begin errors++; $display("FAIL mid_reset_ctrl got busy=%b done=%b count=%0d expected 0/0/0", BUSY, DONE, COUNT); end
    checks++; if (R_ADDR !== 8'd0 || W_ADDR !== 8'd0 || W_WE !== 1'b0 || W_DATA !== 16'd0)
      begin errors++; $display("FAIL mid_reset_mem got r=%0h w=%0h we=%b d=%0h expected 0", R_ADDR, W_ADDR, W_WE, W_DATA); end
    RST = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (DONE || BUSY) seen_done = 1'b1;
      step_cycle();
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL mid_reset_no_done got %b expected 0", seen_done); end
    $display("reset mid-transfer: count=%0d busy=%b", COUNT, BUSY);
  endtask

`ifdef MEM_COPY_CHKSUM_EN
  task automatic test_chksum();
    int d, w, b; logic [8:0] c;
    fill_mem();
    run_copy(8'h01, 8'hA0, 9'd4, d, w, b, c);
    checks++; if (CHKSUM !== 16'd10) begin errors++; $display("FAIL chksum got %0d expected 10", CHKSUM); end
    step_cycle();
    checks++; if (CHKSUM !== 16'd10) begin errors++; $display("FAIL chksum_hold got %0d expected 10", CHKSUM); end
  endtask
`endif

  initial begin
    RST = 1'b1; START = 1'b0; ABORT = 1'b0;
    SRC = '0; DST = '0; LEN = '0; fill_req = 1'b0;
    test_reset();
    test_basic();
    test_overlap();
    test_wrap();
    test_len_edges();
    test_abort();
    test_abort_vs_start();
    test_reset_mid();
`ifdef MEM_COPY_CHKSUM_EN
    test_chksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
